lcd_draw_scheduler: RTL and testbench
=====================================

// Module: lcd_draw_scheduler
// PURPOSE
//  Shares the single PCD8544 SPI master among N_REQ draw requesters (pet sprite, icons, status bar).
//  Round-robin grants one request at a time, then emits set-Y (bank) and set-X (column) commands,
//  then len data bytes read from the shared sprite ROM. Sits between the draw clients and spi_master;
//  the init/wipe sequencer releases the SPI master before this block starts issuing.
// PARAMETERS
//  N_REQ   3   number of requesters
//  ADDR_W  9   sprite ROM address width
// PORTS
//  clk        in   1            system clock
//  reset      in   1            synchronous, active-low
//  req        in   N_REQ        level request per client; held until its done pulse
//  req_col    in   7*N_REQ      start column per client (0..83)
//  req_bank   in   3*N_REQ      start bank per client (0..5)
//  req_len    in   7*N_REQ      byte count per client (0..84)
//  req_addr   in   ADDR_W*N_REQ ROM base address per client
//  grant      out  N_REQ        one-hot, 1-cycle pulse when a request is latched
//  done       out  N_REQ        one-hot, 1-cycle pulse when that request's last byte is accepted
//  busy       out  1            high from grant cycle until done cycle inclusive
//  rom_addr   out  ADDR_W       sprite ROM read address
//  rom_data   in   8            ROM data, valid 1 cycle after rom_addr
//  spi_start  out  1            byte on spi_data/spi_dc is valid for transfer
//  spi_dc     out  1            0 = command, 1 = display data
//  spi_data   out  8            byte to send
//  spi_avail  in   1            1-cycle pulse: master accepted the current byte
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): state IDLE, RR pointer 0; grant, done, busy, spi_start, spi_dc = 0;
//    spi_data = 8'h00, rom_addr = 0. A transfer in flight is abandoned; no done pulse is issued.
//  - IDLE: if any req bit is set, pick the first set bit at or after the RR pointer (wrapping).
//    Latch col/bank/len/addr of the winner, pulse grant, set busy, and go to CMD_Y.
//    The RR pointer becomes winner+1 mod N_REQ.
//  - Latched fields are immune to later changes on req_* inputs. A req drop after grant is ignored.
//  - Saturation on latch: col>83 -> 83, bank>5 -> 5, len>84 -> 84.
//  - CMD_Y: spi_start=1, spi_dc=0, spi_data=8'h40|bank. On spi_avail go to CMD_X.
//  - CMD_X: spi_dc=0, spi_data=8'h80|col. On spi_avail go to FETCH, or to DONE if len==0.
//  - FETCH: spi_start=0, rom_addr=base+idx (idx starts at 0). Next cycle go to LOAD.
//  - LOAD: register rom_data into spi_data, spi_dc=1, go to DATA.
//  - DATA: spi_start=1. On spi_avail, idx++; go to DONE if idx+1==len, else FETCH.
//  - Byte throughput: 2 cycles of overhead per byte, plus the SPI time.
//  - spi_start is low in IDLE, FETCH, LOAD and DONE. The master must not start a byte while spi_start=0.
//  - DONE: pulse done[winner], clear busy, spi_start=0, return to IDLE. A new grant is possible next cycle.
//  - spi_avail seen outside CMD_Y/CMD_X/DATA is ignored.
//  - Column overflow (col+len>84): the block does not split the burst. The controller's auto-increment
//    wraps into the next bank.
//  - rom_addr arithmetic is ADDR_W bits, wrapping modulo 2^ADDR_W.
// STRUCTURE
//  - Shared package lcd_pkg: PCD8544 constants CMD_SET_Y=8'h40, CMD_SET_X=8'h80,
//    LCD_COLS=84, LCD_BANKS=6, plus the scheduler state encoding
//    (IDLE, CMD_Y, CMD_X, FETCH, LOAD, DATA, DONE).
//  - Sub-module rr_arbiter (N_REQ): req, advance pulse -> one-hot winner, with the pointer held internally.
//  - Sequencer FSM, latched request registers, and a 7-bit idx counter live in this module.
// TESTING
//  1. Single req[0]: col=10, bank=2, len=3, addr=0x020, ROM[0x20..22]=AA,BB,CC.
//     -> SPI stream (dc,data) = (0,42),(0,8A),(1,AA),(1,BB),(1,CC).
//     -> grant[0] once, done[0] once, busy low after.
//  2. req=3'b111 held, RR pointer 0.
//     -> grants in order 0,1,2,0. No two bursts interleave, and each done precedes the next grant.
//  3. len=0, col=0, bank=0.
//     -> only (0,40),(0,80) are sent. done pulses after the second avail, and rom_addr is never advanced.
//  4. col=100, bank=7, len=90.
//     -> commands 8'h45 and 8'hD3 are sent, followed by exactly 84 data bytes.
//  5. reset driven low during DATA (idx=1).
//     -> next cycle all outputs are 0 and there is no done pulse.
//     -> after release, pending req[1] is granted first (pointer 0 -> lowest set bit).
//  6. Spurious spi_avail in IDLE/FETCH, and req_col changed after grant.
//     -> no state change. Emitted bytes match the values latched at grant.

Source files
------------

// File: rtl/lcd_pkg.sv
// PCD8544 command constants, field widths and the draw scheduler state encoding.
package lcd_pkg;

    localparam logic [7:0]  CMD_SET_Y = 8'h40;
    localparam logic [7:0]  CMD_SET_X = 8'h80;
    localparam int unsigned LCD_COLS  = 84;
    localparam int unsigned LCD_BANKS = 6;
    localparam int unsigned COL_W     = 7;
    localparam int unsigned BANK_W    = 3;
    localparam int unsigned LEN_W     = 7;

    typedef enum logic [2:0] {
        IDLE,
        CMD_Y,
        CMD_X,
        FETCH,
        LOAD,
        DATA,
        DONE
    } sched_state_t;

    // Clamp request fields to the panel geometry.
    function automatic logic [COL_W-1:0] sat_col(input logic [COL_W-1:0] c);
        return (c > COL_W'(LCD_COLS - 1)) ? COL_W'(LCD_COLS - 1) : c;
    endfunction

    function automatic logic [BANK_W-1:0] sat_bank(input logic [BANK_W-1:0] b);
        return (b > BANK_W'(LCD_BANKS - 1)) ? BANK_W'(LCD_BANKS - 1) : b;
    endfunction

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(LCD_COLS)) ? LEN_W'(LCD_COLS) : l;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner, pointer moves past the winner on advance.
module rr_arbiter #(
    parameter int unsigned N_REQ = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] winner_c
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic             found;

    // First set bit at or after the pointer, then wrap to the lowest set bit.
    always_comb begin
        winner_c = '0;
        win_idx  = '0;
        found    = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found   = 1'b1;
                win_idx = PTR_W'(i);
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!found && req[i]) begin
                found   = 1'b1;
                win_idx = PTR_W'(i);
            end
        end
        if (found) begin
            winner_c[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/lcd_draw_scheduler.sv
// Shares one PCD8544 SPI master among draw clients: set-Y, set-X, then len bytes from sprite ROM.
module lcd_draw_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [7*N_REQ-1:0]      req_col,
    input  logic [3*N_REQ-1:0]      req_bank,
    input  logic [7*N_REQ-1:0]      req_len,
    input  logic [ADDR_W*N_REQ-1:0] req_addr,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic                    busy,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [7:0]              rom_data,
    output logic                    spi_start,
    output logic                    spi_dc,
    output logic [7:0]              spi_data,
    input  logic                    spi_avail
);

    sched_state_t      state;
    logic [N_REQ-1:0]  winner_c;
    logic [N_REQ-1:0]  lat_win;
    logic [COL_W-1:0]  sel_col;
    logic [COL_W-1:0]  lat_col;
    logic [BANK_W-1:0] sel_bank;
    logic [LEN_W-1:0]  sel_len;
    logic [LEN_W-1:0]  lat_len;
    logic [LEN_W-1:0]  idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] lat_addr;
    logic              advance_c;

    assign advance_c = (state == IDLE);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .advance  (advance_c),
        .winner_c (winner_c)
    );

    // Route the winning client's request fields.
    always_comb begin
        sel_col  = '0;
        sel_bank = '0;
        sel_len  = '0;
        sel_addr = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (winner_c[i]) begin
                sel_col  = req_col[i*COL_W +: COL_W];
                sel_bank = req_bank[i*BANK_W +: BANK_W];
                sel_len  = req_len[i*LEN_W +: LEN_W];
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            spi_start <= 1'b0;
            spi_dc    <= 1'b0;
            spi_data  <= 8'h00;
            rom_addr  <= '0;
            lat_win   <= '0;
            lat_col   <= '0;
            lat_len   <= '0;
            lat_addr  <= '0;
            idx       <= '0;
        end else begin
            grant <= '0;
            done  <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        lat_win   <= winner_c;
                        lat_col   <= sat_col(sel_col);
                        lat_len   <= sat_len(sel_len);
                        lat_addr  <= sel_addr;
                        idx       <= '0;
                        grant     <= winner_c;
                        busy      <= 1'b1;
                        spi_start <= 1'b1;
                        spi_dc    <= 1'b0;
                        spi_data  <= CMD_SET_Y | 8'(sat_bank(sel_bank));
                        state     <= CMD_Y;
                    end
                end
                CMD_Y: begin
                    if (spi_avail) begin
                        spi_data <= CMD_SET_X | 8'(lat_col);
                        state    <= CMD_X;
                    end
                end
                CMD_X: begin
                    if (spi_avail) begin
                        spi_start <= 1'b0;
                        if (lat_len == '0) begin
                            done  <= lat_win;
                            state <= DONE;
                        end else begin
                            rom_addr <= lat_addr;
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    spi_data  <= rom_data;
                    spi_dc    <= 1'b1;
                    spi_start <= 1'b1;
                    state     <= DATA;
                end
                DATA: begin
                    if (spi_avail) begin
                        spi_start <= 1'b0;
                        idx       <= idx + LEN_W'(1);
                        if ((idx + LEN_W'(1)) == lat_len) begin
                            done  <= lat_win;
                            state <= DONE;
                        end else begin
                            rom_addr <= lat_addr + ADDR_W'(idx + LEN_W'(1));
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy   <= 1'b0;
                    spi_dc <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_draw_scheduler.sv
// Randomized bench for lcd_draw_scheduler with a ROM model, an SPI master model and a burst-level reference.
module tb_lcd_draw_scheduler;

    localparam int unsigned N_REQ  = 3;
    localparam int unsigned ADDR_W = 9;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [7*N_REQ-1:0]      req_col;
    logic [3*N_REQ-1:0]      req_bank;
    logic [7*N_REQ-1:0]      req_len;
    logic [ADDR_W*N_REQ-1:0] req_addr;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic                    busy;
    logic [ADDR_W-1:0]       rom_addr;
    logic [7:0]              rom_data;
    logic                    spi_start;
    logic                    spi_dc;
    logic [7:0]              spi_data;
    logic                    spi_avail;

    lcd_draw_scheduler #(.N_REQ(N_REQ), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_col   (req_col),
        .req_bank  (req_bank),
        .req_len   (req_len),
        .req_addr  (req_addr),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .spi_start (spi_start),
        .spi_dc    (spi_dc),
        .spi_data  (spi_data),
        .spi_avail (spi_avail)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rom_mem [0:511];
    logic [8:0] cap_q [$];

    // Reference state: requester fields, pending set, arbitration pointer, last ROM address.
    int         f_col  [N_REQ];
    int         f_bank [N_REQ];
    int         f_len  [N_REQ];
    int         f_addr [N_REQ];
    bit         pend   [N_REQ];
    int         m_ptr;
    logic [8:0] m_rom_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Environment: bus monitor, 1-cycle-latency ROM, SPI master with random accept delay and spurious pulses.
    initial begin
        int         cyc = 0;
        int         avail_cyc = 0;
        int         wait_cnt = 0;
        bit         in_burst = 0;
        logic [8:0] addr_prev = '0;
        spi_avail = 1'b0;
        rom_data  = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset !== 1'b1) begin
                in_burst  = 0;
                wait_cnt  = 0;
                spi_avail = 1'b0;
            end else begin
                if (grant != '0) begin
                    check_eq("grant_single_pulse", 32'(in_burst), 32'd0);
                    check_eq("grant_onehot", 32'($countones(grant)), 32'd1);
                    in_burst = 1;
                end
                check_eq("busy", 32'(busy), 32'(in_burst));
                if (!in_burst) check_eq("start_low_idle", 32'(spi_start), 32'd0);
                if (done != '0) begin
                    check_eq("done_in_burst", 32'(in_burst), 32'd1);
                    check_eq("done_latency", 32'(cyc - avail_cyc), 32'd1);
                    in_burst = 0;
                end
                spi_avail = 1'b0;
                if (spi_start) begin
                    if (wait_cnt == 0) begin
                        spi_avail = 1'b1;
                        cap_q.push_back({spi_dc, spi_data});
                        avail_cyc = cyc;
                        wait_cnt  = $urandom_range(0, 3);
                    end else begin
                        wait_cnt--;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    spi_avail = 1'b1;
                end
            end
            rom_data  = rom_mem[addr_prev];
            addr_prev = rom_addr;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_fields(input int i);
        req_col[i*7 +: 7]   = 7'(f_col[i]);
        req_bank[i*3 +: 3]  = 3'(f_bank[i]);
        req_len[i*7 +: 7]   = 7'(f_len[i]);
        req_addr[i*9 +: 9]  = 9'(f_addr[i]);
        req[i]              = 1'b1;
        pend[i]             = 1;
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit any_pend();
        return pend[0] || pend[1] || pend[2];
    endfunction

    // Serve one burst: expected winner, then expected byte stream and final ROM address.
    task automatic service_one();
        int         w = -1;
        int         ecol, ebank, elen;
        logic [2:0] g = '0;
        logic [2:0] d = '0;
        logic [8:0] exp_q [$];
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (w < 0 && pend[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
        end
        for (int t = 0; t < 200 && g == '0; t++) begin
            @(negedge clk);
            g = grant;
        end
        check_eq("grant_winner", 32'(g), 32'(1 << w));
        if (g == '0) begin
            req = '0;
            for (int k = 0; k < int'(N_REQ); k++) pend[k] = 0;
            return;
        end
        m_ptr   = (w + 1) % N_REQ;
        pend[w] = 0;
        ecol  = sat(f_col[w], 83);
        ebank = sat(f_bank[w], 5);
        elen  = sat(f_len[w], 84);
        exp_q.push_back(9'(64 + ebank));
        exp_q.push_back(9'(128 + ecol));
        for (int k = 0; k < elen; k++) exp_q.push_back(9'(256 + int'(rom_mem[(f_addr[w] + k) % 512])));
        if (elen > 0) m_rom_addr = 9'((f_addr[w] + elen - 1) % 512);
        if ($urandom_range(0, 1) == 1) begin
            req_col[w*7 +: 7]  = 7'($urandom);
            req_bank[w*3 +: 3] = 3'($urandom);
            req_len[w*7 +: 7]  = 7'($urandom);
            req_addr[w*9 +: 9] = 9'($urandom);
        end
        if ($urandom_range(0, 3) == 0) req[w] = 1'b0;
        for (int t = 0; t < 3000 && d == '0; t++) begin
            @(negedge clk);
            d = done;
        end
        check_eq("done_onehot", 32'(d), 32'(1 << w));
        check_eq("stream_len", 32'(cap_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
            check_eq($sformatf("byte%0d_req%0d", k, w), 32'(cap_q[k]), 32'(exp_q[k]));
        end
        check_eq("rom_addr_final", 32'(rom_addr), 32'(m_rom_addr));
        req[w] = 1'b0;
        cap_q.delete();
    endtask

    initial begin
        logic [2:0] g;
        reset    = 1'b0;
        req      = '0;
        req_col  = '0;
        req_bank = '0;
        req_len  = '0;
        req_addr = '0;
        m_ptr      = 0;
        m_rom_addr = '0;
        for (int k = 0; k < int'(N_REQ); k++) pend[k] = 0;
        for (int i = 0; i < 512; i++) rom_mem[i] = 8'($urandom);
        rom_mem[32'h20] = 8'hAA;
        rom_mem[32'h21] = 8'hBB;
        rom_mem[32'h22] = 8'hCC;
        repeat (3) @(negedge clk);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_start", 32'(spi_start), 32'd0);
        check_eq("rst_dc", 32'(spi_dc), 32'd0);
        check_eq("rst_data", 32'(spi_data), 32'd0);
        check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single basic burst, then empty burst, then saturating burst.
        f_col[0] = 10;  f_bank[0] = 2; f_len[0] = 3;  f_addr[0] = 32'h20;
        drive_fields(0);
        service_one();
        f_col[1] = 0;   f_bank[1] = 0; f_len[1] = 0;  f_addr[1] = 32'h55;
        drive_fields(1);
        service_one();
        f_col[2] = 100; f_bank[2] = 7; f_len[2] = 90; f_addr[2] = 32'h1F0;
        drive_fields(2);
        service_one();

        // Reset in the middle of a data burst; pointer must restart at 0.
        f_col[1] = 5; f_bank[1] = 1; f_len[1] = 6; f_addr[1] = 32'h100;
        drive_fields(1);
        g = '0;
        for (int t = 0; t < 200 && g == '0; t++) begin
            @(negedge clk);
            g = grant;
        end
        check_eq("pre_reset_grant", 32'(g), 32'b010);
        m_ptr = 2;
        for (int t = 0; t < 500 && !(cap_q.size() >= 3 && spi_start && spi_dc); t++) @(negedge clk);
        reset = 1'b0;
        f_col[2] = 20; f_bank[2] = 3; f_len[2] = 4; f_addr[2] = 32'h1FE;
        drive_fields(2);
        @(negedge clk);
        check_eq("mid_rst_grant", 32'(grant), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_start", 32'(spi_start), 32'd0);
        check_eq("mid_rst_dc", 32'(spi_dc), 32'd0);
        check_eq("mid_rst_data", 32'(spi_data), 32'd0);
        check_eq("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        check_eq("mid_rst_no_done", 32'(done), 32'd0);
        reset      = 1'b1;
        m_ptr      = 0;
        m_rom_addr = '0;
        pend[1]    = 1;
        cap_q.delete();
        while (any_pend()) service_one();

        // All three contending, then client 0 again.
        for (int i = 0; i < int'(N_REQ); i++) begin
            f_col[i] = 8 * i; f_bank[i] = i; f_len[i] = 2 + i; f_addr[i] = 64 * i;
            drive_fields(i);
        end
        while (any_pend()) service_one();
        drive_fields(0);
        service_one();

        // Random contention rounds.
        for (int r = 0; r < 30; r++) begin
            int mask = $urandom_range(1, 7);
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (mask[i]) begin
                    f_col[i]  = $urandom_range(0, 110);
                    f_bank[i] = $urandom_range(0, 7);
                    f_len[i]  = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 100) : $urandom_range(0, 12);
                    f_addr[i] = $urandom_range(0, 511);
                    drive_fields(i);
                end
            end
            while (any_pend()) service_one();
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
